// File: rtl/addsub_pkg.sv
// Shared types and byte-add helper for the byte-serial adder/subtractor.
// Imported by byte_add_cell and multiword_addsub.
package addsub_pkg;

   localparam int BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // 9-bit result {carry, sum} of a + b + cin
   function automatic logic [BYTE_W:0] add_byte(
      input byte_t a,
      input byte_t b,
      input logic  cin
   );
      return {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/byte_add_cell.sv
// Combinational one-byte add/subtract cell with carry and signed overflow.
// Subtraction is a + ~b + 1; the caller supplies cin=1 on the first byte.
module byte_add_cell
   import addsub_pkg::*;
(
   input  byte_t i_a,
   input  byte_t i_b,
   input  logic  i_cin,
   input  logic  i_inv_b,
   output byte_t o_s,
   output logic  o_cout,
   output logic  o_ovf
);

   byte_t           w_b;
   logic [BYTE_W:0] w_sum;

   // Effective B operand, 9-bit sum and overflow from the sign bits
   always_comb begin
      w_b    = i_inv_b ? ~i_b : i_b;
      w_sum  = add_byte(i_a, w_b, i_cin);
      o_s    = w_sum[BYTE_W-1:0];
      o_cout = w_sum[BYTE_W];
      o_ovf  = (i_a[BYTE_W-1] == w_b[BYTE_W-1]) &&
               (w_sum[BYTE_W-1] != i_a[BYTE_W-1]);
   end

endmodule

// File: rtl/multiword_addsub.sv
// Byte-serial N-byte adder/subtractor, LSB first, ready/valid both sides.
// Optional sticky whole-word zero flag: define ADDSUB_ZERO_FLAG_EN.
module multiword_addsub
   import addsub_pkg::*;
#(
   parameter int WORD_BYTES = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  in_valid,
   output logic  in_ready,
   input  byte_t a_byte,
   input  byte_t b_byte,
   input  logic  sub,
   output logic  out_valid,
   input  logic  out_ready,
   output byte_t sum_byte,
   output logic  out_last,
   output logic  carry_out,
   output logic  ovf,
   output logic  zero
);

   localparam int CNT_W =
      (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int LAST_BEAT = WORD_BYTES - 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   op_e              r_mode;
   logic             r_out_valid;
   byte_t            r_sum;
   logic             r_last;
   logic             r_cout;
   logic             r_ovf;

   logic  w_accept;
   logic  w_xfer;
   logic  w_start;
   logic  w_last;
   logic  w_cin;
   op_e   w_mode;
   byte_t w_s;
   logic  w_c;
   logic  w_v;

   // Single output stage: accept when empty or draining; never during clr
   always_comb begin
      in_ready = (!r_out_valid || out_ready) && !clr;
      w_accept = in_valid && in_ready;
      w_xfer   = r_out_valid && out_ready;
      w_start  = (r_cnt == '0);
      w_last   = (r_cnt == CNT_W'(LAST_BEAT));
      w_mode   = w_start ? op_e'(sub) : r_mode;
      w_cin    = w_start ? sub : r_carry;
   end

   byte_add_cell u_cell (
      .i_a     (a_byte),
      .i_b     (b_byte),
      .i_cin   (w_cin),
      .i_inv_b (w_mode == OP_SUB),
      .o_s     (w_s),
      .o_cout  (w_c),
      .o_ovf   (w_v)
   );

   // Beat counter, inter-beat carry/mode and the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_mode      <= OP_ADD;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_last      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (clr) begin
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
         r_last      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_accept) begin
         r_cnt       <= w_last ? '0 : r_cnt + CNT_W'(1);
         r_carry     <= w_c;
         r_mode      <= w_mode;
         r_out_valid <= 1'b1;
         r_sum       <= w_s;
         r_last      <= w_last;
         r_cout      <= w_last & w_c;
         r_ovf       <= w_last & w_v;
      end else if (w_xfer) begin
         r_out_valid <= 1'b0;
         r_last      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end
   end

`ifdef ADDSUB_ZERO_FLAG_EN
   logic r_zacc;
   logic r_zero;
   logic w_znew;

   // Running "all bytes zero so far", restarted on beat 0
   always_comb begin
      w_znew = (w_start ? 1'b1 : r_zacc) && (w_s == '0);
   end

   // Sticky zero accumulator; reported only with the last byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zacc <= 1'b0;
         r_zero <= 1'b0;
      end else if (clr) begin
         r_zacc <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_accept) begin
         r_zacc <= w_znew;
         r_zero <= w_last & w_znew;
      end else if (w_xfer) begin
         r_zero <= 1'b0;
      end
   end

   assign zero = r_zero;
`else
   assign zero = 1'b0;
`endif

   assign out_valid = r_out_valid;
   assign sum_byte  = r_sum;
   assign out_last  = r_last;
   assign carry_out = r_cout;
   assign ovf       = r_ovf;

endmodule
